// File: rtl/j1_data_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : j1_data_cache_pkg
//  Purpose  : Shared geometry constants and FSM state encoding for the J1
//             direct-mapped write-through data cache.
//  Revision : 1.0 - initial release
// ============================================================================
package j1_data_cache_pkg;

    // Default cache geometry: 64 lines of 4 words, 14-bit word address.
    localparam int c_cache_index_bits  = 6;
    localparam int c_cache_offset_bits = 2;
    localparam int c_cache_line_words  = 1 << c_cache_offset_bits;
    localparam int c_cache_addr_w      = 14;
    localparam int c_cache_data_w      = 32;

    // Controller state codes.
    localparam logic [1:0] c_cache_idle     = 2'd0;
    localparam logic [1:0] c_cache_wb_write = 2'd1;
    localparam logic [1:0] c_cache_refill   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = c_cache_idle,
        S_WB_WRITE = c_cache_wb_write,
        S_REFILL   = c_cache_refill
    } cache_state_e;

endpackage : j1_data_cache_pkg
`default_nettype wire

// File: rtl/j1_dcache_array.sv
`default_nettype none
// ============================================================================
//  Module   : j1_dcache_array
//  Purpose  : Valid bits, tag RAM and data RAM of the data cache. Reads are
//             asynchronous; word writes and line tag/valid sets are
//             synchronous. Only the valid bits are cleared by reset.
//  Revision : 1.0 - initial release
// ============================================================================
module j1_dcache_array #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_W       = 6,
    parameter int DATA_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    // asynchronous lookup port
    input  logic [INDEX_BITS-1:0]  i_rd_index,
    input  logic [OFFSET_BITS-1:0] i_rd_offset,
    output logic                   o_rd_valid,
    output logic [TAG_W-1:0]       o_rd_tag,
    output logic [DATA_W-1:0]      o_rd_data,
    // word write port
    input  logic                   i_word_we,
    input  logic [INDEX_BITS-1:0]  i_word_index,
    input  logic [OFFSET_BITS-1:0] i_word_offset,
    input  logic [DATA_W-1:0]      i_word_data,
    // line tag/valid set port
    input  logic                   i_line_set,
    input  logic [INDEX_BITS-1:0]  i_line_index,
    input  logic [TAG_W-1:0]       i_line_tag
);

    localparam int c_lines   = 1 << INDEX_BITS;
    localparam int c_entries = 1 << (INDEX_BITS + OFFSET_BITS);

    logic [c_lines-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [0:c_lines-1];
    logic [DATA_W-1:0]  r_data [0:c_entries-1];

    // Lookup is purely combinational so read hits cost no latency.
    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[{i_rd_index, i_rd_offset}];

    // Valid bits: cleared on reset, set when a line finishes refilling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_line_set) begin
            r_valid[i_line_index] <= 1'b1;
        end
    end

    // Tag RAM is loaded together with the valid bit of the line.
    always_ff @(posedge clk) begin
        if (i_line_set) begin
            r_tag[i_line_index] <= i_line_tag;
        end
    end

    // Data RAM word writes (refill words and write hits).
    always_ff @(posedge clk) begin
        if (i_word_we) begin
            r_data[{i_word_index, i_word_offset}] <= i_word_data;
        end
    end

endmodule : j1_dcache_array
`default_nettype wire

// File: rtl/j1_data_cache.sv
`default_nettype none
// ============================================================================
//  Module   : j1_data_cache
//  Purpose  : Direct-mapped, write-through, no-write-allocate data cache for
//             the J1 core. Read hits return combinationally; read misses
//             refill a whole line over a single-word req/ack memory port;
//             writes go through a one-entry write buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module j1_data_cache
    import j1_data_cache_pkg::*;
#(
    parameter int INDEX_BITS  = c_cache_index_bits,
    parameter int OFFSET_BITS = c_cache_offset_bits,
    parameter int ADDR_W      = c_cache_addr_w,
    parameter int DATA_W      = c_cache_data_w
) (
    input  logic              clk,
    input  logic              rst,
    // core data-side interface
    input  logic              cache_data_valid,
    input  logic              cache_data_rd_wr,
    input  logic [ADDR_W-1:0] cache_data_addr,
    input  logic [DATA_W-1:0] cache_data_din,
    output logic [DATA_W-1:0] cache_data_dout,
    output logic              cache_data_miss,
    output logic              cache_data_wr_wait,
    // memory interface
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_tag_w  = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int c_line_w = ADDR_W - OFFSET_BITS;

    // ---------------------------------------------------------------- address
    logic [c_tag_w-1:0]     w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic [OFFSET_BITS-1:0] w_offset;

    assign w_tag    = cache_data_addr[ADDR_W-1 -: c_tag_w];
    assign w_index  = cache_data_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_offset = cache_data_addr[OFFSET_BITS-1:0];

    // ---------------------------------------------------------------- state
    cache_state_e           r_state;
    cache_state_e           w_state_nxt;

    logic                   r_wb_full;
    logic [ADDR_W-1:0]      r_wb_addr;
    logic [DATA_W-1:0]      r_wb_data;

    logic [OFFSET_BITS-1:0] r_cnt;
    logic [OFFSET_BITS-1:0] w_cnt_nxt;
    logic [c_line_w-1:0]    r_line;       // {tag, index} of the line being refilled
    logic [c_line_w-1:0]    w_line_nxt;

    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic                   w_mem_req_nxt;
    logic                   w_mem_we_nxt;
    logic [ADDR_W-1:0]      w_mem_addr_nxt;
    logic [DATA_W-1:0]      w_mem_wdata_nxt;

    logic                   w_wb_clear;
    logic                   w_fill_we;
    logic                   w_fill_last;

    // ---------------------------------------------------------------- array
    logic                   w_arr_valid;
    logic [c_tag_w-1:0]     w_arr_tag;
    logic [DATA_W-1:0]      w_arr_data;
    logic                   w_arr_we;
    logic [INDEX_BITS-1:0]  w_arr_widx;
    logic [OFFSET_BITS-1:0] w_arr_woff;
    logic [DATA_W-1:0]      w_arr_wdata;
    logic                   w_arr_set;

    logic                   w_hit;
    logic                   w_rd_req;
    logic                   w_wr_req;
    logic                   w_wr_blocked;
    logic                   w_wr_accept;
    logic                   w_ack;

    j1_dcache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_W       (c_tag_w),
        .DATA_W      (DATA_W)
    ) u_array (
        .clk           (clk),
        .rst           (rst),
        .i_rd_index    (w_index),
        .i_rd_offset   (w_offset),
        .o_rd_valid    (w_arr_valid),
        .o_rd_tag      (w_arr_tag),
        .o_rd_data     (w_arr_data),
        .i_word_we     (w_arr_we),
        .i_word_index  (w_arr_widx),
        .i_word_offset (w_arr_woff),
        .i_word_data   (w_arr_wdata),
        .i_line_set    (w_arr_set),
        .i_line_index  (r_line[INDEX_BITS-1:0]),
        .i_line_tag    (r_line[c_line_w-1 -: c_tag_w])
    );

    assign w_hit    = w_arr_valid & (w_arr_tag == w_tag);
    assign w_rd_req = cache_data_valid & ~cache_data_rd_wr;
    assign w_wr_req = cache_data_valid &  cache_data_rd_wr;
    assign w_ack    = r_mem_req & mem_ack;

    // A write is held off while the buffer is occupied or the controller is
    // busy; the core is stalled during refills, so that case is defensive.
    assign w_wr_blocked = r_wb_full | (r_state != S_IDLE);
    assign w_wr_accept  = ~rst & w_wr_req & ~w_wr_blocked;

    // Refill words have priority on the write port; a write hit can only be
    // accepted in IDLE, so the two never collide.
    assign w_arr_we    = ~rst & (w_fill_we | (w_wr_accept & w_hit));
    assign w_arr_widx  = w_fill_we ? r_line[INDEX_BITS-1:0] : w_index;
    assign w_arr_woff  = w_fill_we ? r_cnt : w_offset;
    assign w_arr_wdata = w_fill_we ? mem_rdata : cache_data_din;
    assign w_arr_set   = ~rst & w_fill_last;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Core-facing handshake: combinational hit data, miss and write stall.
    always_comb begin
        cache_data_dout    = '0;
        cache_data_miss    = 1'b0;
        cache_data_wr_wait = 1'b0;
        if (!rst) begin
            if (w_rd_req) begin
                if (w_hit) begin
                    cache_data_dout = w_arr_data;
                end else begin
                    cache_data_miss = 1'b1;
                end
            end
            if (w_wr_req && w_wr_blocked) begin
                cache_data_wr_wait = 1'b1;
            end
        end
    end

    // Controller next state and next memory-port values.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cnt_nxt       = r_cnt;
        w_line_nxt      = r_line;
        w_wb_clear      = 1'b0;
        w_fill_we       = 1'b0;
        w_fill_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Draining the buffer first keeps read-after-write ordered.
                if (r_wb_full) begin
                    w_state_nxt     = S_WB_WRITE;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = r_wb_addr;
                    w_mem_wdata_nxt = r_wb_data;
                end else if (w_rd_req && !w_hit) begin
                    w_state_nxt    = S_REFILL;
                    w_line_nxt     = {w_tag, w_index};
                    w_cnt_nxt      = '0;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = {w_tag, w_index, {OFFSET_BITS{1'b0}}};
                end
            end
            S_WB_WRITE: begin
                if (w_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_wb_clear    = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_REFILL: begin
                if (w_ack) begin
                    w_fill_we     = 1'b1;
                    w_mem_req_nxt = 1'b0;
                    w_cnt_nxt     = r_cnt + 1'b1;
                    if (r_cnt == {OFFSET_BITS{1'b1}}) begin
                        w_fill_last = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (!r_mem_req) begin
                    // One idle cycle after each ack, then fetch the next word.
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = {r_line, r_cnt};
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Controller state, refill bookkeeping and registered memory outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_line      <= w_line_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // One-entry write buffer: filled on write accept, freed on its mem ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_full <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_wb_clear) begin
            r_wb_full <= 1'b0;
        end else if (w_wr_accept) begin
            r_wb_full <= 1'b1;
            r_wb_addr <= cache_data_addr;
            r_wb_data <= cache_data_din;
        end
    end

endmodule : j1_data_cache
`default_nettype wire

// File: tb/tb_j1_data_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_j1_data_cache
//  Purpose  : Self-checking bench for j1_data_cache with a req/ack memory
//             model that stores writes and logs every completed transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_j1_data_cache;

    logic        clk;
    logic        rst;
    logic        cache_data_valid;
    logic        cache_data_rd_wr;
    logic [13:0] cache_data_addr;
    logic [31:0] cache_data_din;
    logic [31:0] cache_data_dout;
    logic        cache_data_miss;
    logic        cache_data_wr_wait;
    logic        mem_req;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    j1_data_cache dut (
        .clk                (clk),
        .rst                (rst),
        .cache_data_valid   (cache_data_valid),
        .cache_data_rd_wr   (cache_data_rd_wr),
        .cache_data_addr    (cache_data_addr),
        .cache_data_din     (cache_data_din),
        .cache_data_dout    (cache_data_dout),
        .cache_data_miss    (cache_data_miss),
        .cache_data_wr_wait (cache_data_wr_wait),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // ------------------------------------------------------------ memory model
    logic [31:0] mem [0:16383];
    int          ack_delay = 2;
    int          wait_cnt;
    int          n_reads  = 0;
    int          n_writes = 0;
    int          n_events = 0;
    logic [13:0] rlog_addr [0:255];
    int          rlog_seq  [0:255];
    logic [13:0] wlog_addr [0:255];
    logic [31:0] wlog_data [0:255];
    int          wlog_seq  [0:255];

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h1000 + i - 32'h44;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wlog_addr[n_writes & 255] = mem_addr;
                        wlog_data[n_writes & 255] = mem_wdata;
                        wlog_seq[n_writes & 255]  = n_events;
                        n_writes++;
                    end else begin
                        mem_rdata = mem[mem_addr];
                        rlog_addr[n_reads & 255] = mem_addr;
                        rlog_seq[n_reads & 255]  = n_events;
                        n_reads++;
                    end
                    n_events++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single combinational look: request is dropped before the next edge.
    task automatic probe(input logic v, input logic rw, input logic [13:0] a,
                         output logic m, output logic w, output logic [31:0] d);
        @(negedge clk);
        cache_data_valid = v;
        cache_data_rd_wr = rw;
        cache_data_addr  = a;
        cache_data_din   = 32'hA5A5_5A5A;
        #1;
        m = cache_data_miss;
        w = cache_data_wr_wait;
        d = cache_data_dout;
        cache_data_valid = 1'b0;
    endtask

    task automatic do_read(input logic [13:0] a, output logic [31:0] d, output int misses);
        @(negedge clk);
        cache_data_valid = 1'b1;
        cache_data_rd_wr = 1'b0;
        cache_data_addr  = a;
        misses = 0;
        #1;
        while (cache_data_miss && misses < 200) begin
            @(negedge clk);
            #1;
            misses++;
        end
        if (cache_data_miss) begin
            n_total++;
            n_bad++;
            $display("FAIL read_timeout: addr %h still missing after %0d cycles", a, misses);
        end
        d = cache_data_dout;
        cache_data_valid = 1'b0;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [31:0] d,
                            output int waits, output int wlog_at_accept);
        @(negedge clk);
        cache_data_valid = 1'b1;
        cache_data_rd_wr = 1'b1;
        cache_data_addr  = a;
        cache_data_din   = d;
        waits = 0;
        #1;
        while (cache_data_wr_wait && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (cache_data_wr_wait) begin
            n_total++;
            n_bad++;
            $display("FAIL write_timeout: addr %h still waiting after %0d cycles", a, waits);
        end
        wlog_at_accept = n_writes;
        @(posedge clk);
        #2;
        cache_data_valid = 1'b0;
        cache_data_rd_wr = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int k;
        k = 0;
        while (n_writes < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (n_writes < target) begin
            n_total++;
            n_bad++;
            $display("FAIL write_drain: got %0d writes expected %0d", n_writes, target);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        v;
        logic        rw;
        logic [13:0] a;
        logic        em;
        logic        ew;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [0:9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ main test
    initial begin
        logic        m, w;
        logic [31:0] d;
        int          misses, waits, wacc, base_r, base_w, wseq, rseq;

        // Hit/miss probes against the cache after line 0x44 is filled and
        // word 0x46 has been overwritten with 0xDEADBEEF.
        tbl[0] = '{1'b1, 1'b0, 14'h0044, 1'b0, 1'b0, 32'h0000_1000};
        tbl[1] = '{1'b1, 1'b0, 14'h0045, 1'b0, 1'b0, 32'h0000_1001};
        tbl[2] = '{1'b1, 1'b0, 14'h0046, 1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 1'b0, 14'h0047, 1'b0, 1'b0, 32'h0000_1003};
        tbl[4] = '{1'b1, 1'b0, 14'h0048, 1'b1, 1'b0, 32'h0000_0000};
        tbl[5] = '{1'b1, 1'b0, 14'h1044, 1'b1, 1'b0, 32'h0000_0000};
        tbl[6] = '{1'b1, 1'b0, 14'h0144, 1'b1, 1'b0, 32'h0000_0000};
        tbl[7] = '{1'b1, 1'b1, 14'h0044, 1'b0, 1'b0, 32'h0000_0000};
        tbl[8] = '{1'b1, 1'b1, 14'h0300, 1'b0, 1'b0, 32'h0000_0000};
        tbl[9] = '{1'b0, 1'b0, 14'h0044, 1'b0, 1'b0, 32'h0000_0000};

        rst = 1'b1;
        cache_data_valid = 1'b0;
        cache_data_rd_wr = 1'b0;
        cache_data_addr  = '0;
        cache_data_din   = '0;

        // Reset: outputs quiet even with a request present.
        @(posedge clk);
        probe(1'b1, 1'b0, 14'h0045, m, w, d);
        chk("rst_rd_miss", {31'b0, m}, 32'd0);
        chk("rst_rd_dout", d, 32'd0);
        probe(1'b1, 1'b1, 14'h0045, m, w, d);
        chk("rst_wr_wait", {31'b0, w}, 32'd0);
        @(posedge clk);
        #2;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {18'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold read of 0x45: four sequential refill reads 0x44..0x47.
        base_r = n_reads;
        do_read(14'h0045, d, misses);
        chk("cold_dout", d, 32'h0000_1001);
        chk("cold_missed", {31'b0, (misses > 0)}, 32'd1);
        chk("cold_nreads", n_reads - base_r, 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("cold_raddr%0d", k), {18'b0, rlog_addr[(base_r + k) & 255]}, 32'h44 + k);
        probe(1'b1, 1'b0, 14'h0047, m, w, d);
        chk("hit47_miss", {31'b0, m}, 32'd0);
        chk("hit47_dout", d, 32'h0000_1003);

        // Write hit to 0x46: accepted at once, visible the next cycle.
        base_r = n_reads;
        base_w = n_writes;
        do_write(14'h0046, 32'hDEAD_BEEF, waits, wacc);
        chk("wr46_wait", waits, 32'd0);
        probe(1'b1, 1'b0, 14'h0046, m, w, d);
        chk("rd46_miss", {31'b0, m}, 32'd0);
        chk("rd46_dout", d, 32'hDEAD_BEEF);
        wait_writes(base_w + 1);
        chk("wr46_maddr", {18'b0, wlog_addr[base_w & 255]}, 32'h0046);
        chk("wr46_mdata", wlog_data[base_w & 255], 32'hDEAD_BEEF);
        chk("wr46_noread", n_reads - base_r, 32'd0);

        // Table of single-cycle probes.
        for (int i = 0; i < 10; i++) begin
            probe(tbl[i].v, tbl[i].rw, tbl[i].a, m, w, d);
            chk($sformatf("vec%0d_miss", i), {31'b0, m}, {31'b0, tbl[i].em});
            chk($sformatf("vec%0d_wait", i), {31'b0, w}, {31'b0, tbl[i].ew});
            chk($sformatf("vec%0d_dout", i), d, tbl[i].ed);
        end

        // Back-to-back write misses with a 3-cycle ack.
        ack_delay = 3;
        base_w = n_writes;
        do_write(14'h0100, 32'h1111_1111, waits, wacc);
        chk("bb_w1_wait", waits, 32'd0);
        do_write(14'h0200, 32'h2222_2222, waits, wacc);
        chk("bb_w2_wait", waits, 32'd4);
        chk("bb_w2_after_ack", wacc - base_w, 32'd1);
        wait_writes(base_w + 2);
        chk("bb_nwrites", n_writes - base_w, 32'd2);
        chk("bb_addr0", {18'b0, wlog_addr[base_w & 255]}, 32'h0100);
        chk("bb_data0", wlog_data[base_w & 255], 32'h1111_1111);
        chk("bb_addr1", {18'b0, wlog_addr[(base_w + 1) & 255]}, 32'h0200);
        chk("bb_data1", wlog_data[(base_w + 1) & 255], 32'h2222_2222);
        probe(1'b1, 1'b0, 14'h0100, m, w, d);
        chk("bb_100_miss", {31'b0, m}, 32'd1);
        probe(1'b1, 1'b0, 14'h0200, m, w, d);
        chk("bb_200_miss", {31'b0, m}, 32'd1);
        probe(1'b1, 1'b0, 14'h0046, m, w, d);
        chk("bb_46_kept", d, 32'hDEAD_BEEF);
        ack_delay = 2;

        // Write then immediate read of the same missing address.
        base_r = n_reads;
        base_w = n_writes;
        do_write(14'h0300, 32'h0000_0055, waits, wacc);
        do_read(14'h0300, d, misses);
        chk("raw_dout", d, 32'h0000_0055);
        chk("raw_nwrites", n_writes - base_w, 32'd1);
        chk("raw_nreads", n_reads - base_r, 32'd4);
        wseq = wlog_seq[base_w & 255];
        rseq = rlog_seq[base_r & 255];
        chk("raw_first_raddr", {18'b0, rlog_addr[base_r & 255]}, 32'h0300);
        chk("raw_order", {31'b0, (wseq < rseq)}, 32'd1);

        // Conflict: 0x1044 evicts line 0x44.
        base_r = n_reads;
        do_read(14'h1044, d, misses);
        chk("conf_dout", d, 32'h0000_2000);
        chk("conf_nreads", n_reads - base_r, 32'd4);
        probe(1'b1, 1'b0, 14'h0044, m, w, d);
        chk("conf_44_miss", {31'b0, m}, 32'd1);

        // Reset after the second refill ack of line 0x44.
        base_r = n_reads;
        @(negedge clk);
        cache_data_valid = 1'b1;
        cache_data_rd_wr = 1'b0;
        cache_data_addr  = 14'h0044;
        misses = 0;
        while (n_reads < base_r + 2 && misses < 100) begin
            @(negedge clk);
            misses++;
        end
        chk("mid_two_acks", n_reads - base_r, 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cache_data_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid_mem_addr", {18'b0, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        probe(1'b1, 1'b0, 14'h0044, m, w, d);
        chk("mid_44_miss", {31'b0, m}, 32'd1);
        probe(1'b1, 1'b0, 14'h1044, m, w, d);
        chk("mid_1044_miss", {31'b0, m}, 32'd1);
        probe(1'b1, 1'b0, 14'h0300, m, w, d);
        chk("mid_300_miss", {31'b0, m}, 32'd1);
        base_r = n_reads;
        do_read(14'h0044, d, misses);
        chk("mid_refill_dout", d, 32'h0000_1000);
        chk("mid_refill_nreads", n_reads - base_r, 32'd4);
        chk("mid_refill_first", {18'b0, rlog_addr[base_r & 255]}, 32'h0044);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_j1_data_cache
`default_nettype wire
